// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - opcodes, funct codes, ALU and FSM enums shared by the RV32 multi-cycle core
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_MUL  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, MUL} state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - register file: two combinational read ports, one synchronous write port
// Index bits above $clog2(NUM_REGS) are dropped, so RV32E builds alias x16..x31 onto x0..x15.
module rv32_regfile #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0]   regs [NUM_REGS];
  logic [AW-1:0] ra1, ra2, wa;

  assign ra1 = rs1_addr[AW-1:0];
  assign ra2 = rs2_addr[AW-1:0];
  assign wa  = rd_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= rd_data;
    end
  end

  assign rs1_data = (ra1 == '0) ? '0 : regs[ra1];
  assign rs2_data = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/rv32_multicycle_core.sv
// rtl/rv32_multicycle_core.sv - multi-cycle RV32I-subset core with handshaked I/D memories
// Define RV32_MUL_EN to add a 32-cycle shift-add mul; otherwise mul decodes as illegal.
module rv32_multicycle_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NUM_REGS    = 32,
  parameter bit          I_BYTE_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_I,
  output logic [31:0] mem_addr_I,
  input  logic [31:0] mem_rdata_I,
  input  logic        mem_ready_I,
  output logic        mem_req_D,
  output logic        mem_wen_D,
  output logic [31:0] mem_addr_D,
  output logic [31:0] mem_wdata_D,
  input  logic [31:0] mem_rdata_D,
  input  logic        mem_ready_D,
  output logic        retire,
  output logic        illegal
);

  state_t      state, next_state;
  alu_op_t     alu_op;
  logic [31:0] pc, next_pc, ir, addr_q, wdata_q, fetch_word;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, pc_plus4;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, rf_wd, mem_addr_c;
  logic        rf_we, legal, is_mul, mem_latch, illegal_set, retire_c, taken;
`ifdef RV32_MUL_EN
  logic [31:0] mul_a, mul_b, mul_acc;
  logic [4:0]  mul_cnt;
  logic        mul_start;
`endif

  assign fetch_word = I_BYTE_SWAP ? byte_swap(mem_rdata_I) : mem_rdata_I;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign pc_plus4   = pc + 32'd4;
  assign mem_addr_c = rs1_val + ((opcode == STORE) ? imm_s : imm_i);
  assign taken      = (funct3 == F3_BEQ) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);

  rv32_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (rf_wd)
  );

  // Pure decode of IR, kept apart from the FSM so the ALU result never feeds back into it.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rs2_val;
    legal  = 1'b0;
    is_mul = 1'b0;
    case (opcode)
      OP: begin
        legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
          {F7_BASE, F3_OR }: alu_op = ALU_OR;
          {F7_BASE, F3_AND}: alu_op = ALU_AND;
`ifdef RV32_MUL_EN
          {F7_MUL,  F3_MUL}: begin
            alu_op = ALU_MUL;
            is_mul = 1'b1;
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        legal = 1'b1;
        alu_b = imm_i;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: legal  = 1'b0;
        endcase
      end
      LOAD:    legal = (funct3 == F3_LW);
      STORE:   legal = (funct3 == F3_SW);
      BRANCH:  legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      JAL:     legal = 1'b1;
      JALR:    legal = (funct3 == F3_JALR);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = rs1_val - alu_b;
      ALU_AND: alu_res = rs1_val & alu_b;
      ALU_OR:  alu_res = rs1_val | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      default: alu_res = rs1_val + alu_b;
    endcase
  end

  always_comb begin
    next_state  = state;
    next_pc     = pc;
    rf_we       = 1'b0;
    rf_wd       = alu_res;
    mem_latch   = 1'b0;
    illegal_set = 1'b0;
    retire_c    = 1'b0;
`ifdef RV32_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state)
      FETCH: if (mem_ready_I) next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        next_pc    = pc_plus4;
        if (!legal) begin
          illegal_set = 1'b1;
        end else begin
          case (opcode)
            OP, OP_IMM: begin
              if (is_mul) begin
                next_state = MUL;
                next_pc    = pc;
`ifdef RV32_MUL_EN
                mul_start  = 1'b1;
`endif
              end else begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
              end
            end
            LOAD, STORE: begin
              mem_latch  = 1'b1;
              next_state = MEM;
              next_pc    = pc;
            end
            BRANCH: begin
              retire_c = 1'b1;
              if (taken) next_pc = pc + imm_b;
            end
            JAL: begin
              rf_we    = 1'b1;
              rf_wd    = pc_plus4;
              next_pc  = pc + imm_j;
              retire_c = 1'b1;
            end
            JALR: begin
              rf_we    = 1'b1;
              rf_wd    = pc_plus4;
              next_pc  = (rs1_val + imm_i) & ~32'd1;
              retire_c = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        if (mem_ready_D) begin
          rf_we      = (opcode == LOAD);
          rf_wd      = mem_rdata_D;
          next_pc    = pc_plus4;
          retire_c   = 1'b1;
          next_state = FETCH;
        end
      end
      MUL: begin
`ifdef RV32_MUL_EN
        if (mul_cnt == 5'd31) begin
          rf_we      = 1'b1;
          rf_wd      = mul_acc + (mul_b[0] ? mul_a : 32'd0);
          next_pc    = pc_plus4;
          retire_c   = 1'b1;
          next_state = FETCH;
        end
`else
        next_state = FETCH;
`endif
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (state == FETCH && mem_ready_I) ir <= fetch_word;
      if (mem_latch) begin
        addr_q  <= mem_addr_c;
        wdata_q <= rs2_val;
      end
      if (illegal_set) illegal <= 1'b1;
    end
  end

`ifdef RV32_MUL_EN
  // One multiplier bit per cycle: the final partial product is folded in on the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (mul_start) begin
      mul_a   <= rs1_val;
      mul_b   <= rs2_val;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (state == MUL) begin
      if (mul_b[0]) mul_acc <= mul_acc + mul_a;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt + 5'd1;
    end
  end
`endif

  assign mem_req_I   = (state == FETCH) && !rst;
  assign mem_addr_I  = pc;
  assign mem_req_D   = (state == MEM);
  assign mem_wen_D   = (state == MEM) && (opcode == STORE);
  assign mem_addr_D  = addr_q;
  assign mem_wdata_D = wdata_q;
  assign retire      = retire_c;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// tb/tb_rv32_multicycle_core.sv - scoreboard bench: expected fetch PCs and stores queued, compared as the core emits them
module tb_rv32_multicycle_core;

  logic        clk, rst;
  logic        mem_req_I, mem_ready_I, mem_req_D, mem_wen_D, mem_ready_D, retire, illegal;
  logic [31:0] mem_addr_I, mem_rdata_I, mem_addr_D, mem_wdata_D, mem_rdata_D;

  rv32_multicycle_core dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req_I   (mem_req_I),
    .mem_addr_I  (mem_addr_I),
    .mem_rdata_I (mem_rdata_I),
    .mem_ready_I (mem_ready_I),
    .mem_req_D   (mem_req_D),
    .mem_wen_D   (mem_wen_D),
    .mem_addr_D  (mem_addr_D),
    .mem_wdata_D (mem_wdata_D),
    .mem_rdata_D (mem_rdata_D),
    .mem_ready_D (mem_ready_D),
    .retire      (retire),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] data;} st_t;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic [31:0] exp_pc [$];
  st_t         exp_st [$];
  int          total, bad, cyc, ret_cnt, n_xf, n_xs, i_wait, d_wait, icnt, dcnt;
  int          ret_cyc [0:63];
  bit          spur;
  logic        ill_snap;
  logic [31:0] hold_addr, hold_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic put(input int addr, input logic [31:0] insn);
    imem[addr >> 2] = swap(insn);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.addr = a;
    s.data = d;
    exp_st.push_back(s);
  endtask

  // One clock: respond as the memories at the falling edge, then sample the core 1 time unit later.
  task automatic cycle();
    st_t         s;
    logic [31:0] p;
    @(negedge clk);
    cyc++;
    if (rst) begin
      mem_ready_I = 1'b0;
      mem_ready_D = 1'b0;
      icnt = 0;
      dcnt = 0;
    end else begin
      if (mem_req_I) begin
        if (icnt >= i_wait) begin
          mem_ready_I = 1'b1;
          mem_rdata_I = imem[mem_addr_I[7:2]];
          icnt = 0;
        end else begin
          mem_ready_I = 1'b0;
          mem_rdata_I = 32'hDEAD_BEEF;
          icnt++;
        end
      end else begin
        mem_ready_I = spur;
        mem_rdata_I = 32'hDEAD_BEEF;
        icnt = 0;
      end
      if (mem_req_D) begin
        if (dcnt == 0) begin
          hold_addr  = mem_addr_D;
          hold_wdata = mem_wdata_D;
        end
        if (dcnt >= d_wait) begin
          mem_ready_D = 1'b1;
          mem_rdata_D = dmem[mem_addr_D[7:2]];
          dcnt = 0;
        end else begin
          mem_ready_D = 1'b0;
          mem_rdata_D = 32'hBAD0_0BAD;
          dcnt++;
        end
      end else begin
        mem_ready_D = spur;
        mem_rdata_D = 32'hBAD0_0BAD;
        dcnt = 0;
      end
    end
    #1;
    if (!rst && retire) begin
      if (ret_cnt < 64) ret_cyc[ret_cnt] = cyc;
      ret_cnt++;
    end
    if (!rst && mem_req_I && mem_ready_I) begin
      if (exp_pc.size() == 0) n_xf++;
      else begin
        p = exp_pc.pop_front();
        check("fetch_pc", mem_addr_I, p);
        if (mem_addr_I == 32'h68) ill_snap = illegal;
      end
    end
    if (!rst && mem_req_D && mem_ready_D) begin
      check("d_addr_held", mem_addr_D, hold_addr);
      if (mem_wen_D) begin
        check("d_wdata_held", mem_wdata_D, hold_wdata);
        dmem[mem_addr_D[7:2]] = mem_wdata_D;
        if (exp_st.size() == 0) n_xs++;
        else begin
          s = exp_st.pop_front();
          check("st_addr", mem_addr_D, s.addr);
          check("st_data", mem_wdata_D, s.data);
        end
      end
    end
  endtask

  task automatic run_fetches(input string tag, input int budget);
    for (int n = 0; n < budget && exp_pc.size() > 0; n++) cycle();
    check(tag, exp_pc.size(), 0);
  endtask

  initial begin
    int          pcs1 [28];
    logic [31:0] mul_res;
    total = 0; bad = 0; cyc = 0; ret_cnt = 0; n_xf = 0; n_xs = 0;
    icnt = 0; dcnt = 0; i_wait = 0; d_wait = 3; spur = 1'b0; ill_snap = 1'b0;
    hold_addr = '0; hold_wdata = '0;
    rst = 1'b1;
    mem_ready_I = 1'b0; mem_ready_D = 1'b0;
    mem_rdata_I = '0; mem_rdata_D = '0;
    for (int i = 0; i < 64; i++) begin
      imem[i] = swap(enc_j(0, 0));
      dmem[i] = '0;
    end

    put(32'h00, addi(1, 0, 5));
    put(32'h04, addi(2, 0, -3));
    put(32'h08, enc_r(7'h00, 2, 1, 3'b000, 3));
    put(32'h0c, enc_r(7'h00, 1, 2, 3'b010, 4));
    put(32'h10, enc_r(7'h20, 1, 2, 3'b000, 5));
    put(32'h14, enc_s(0, 3, 0));
    put(32'h18, enc_s(4, 4, 0));
    put(32'h1c, enc_s(12, 5, 0));
    put(32'h20, enc_j(16, 1));
    put(32'h24, addi(3, 0, 77));
    put(32'h28, enc_s(16, 1, 0));
    put(32'h2c, enc_j(8, 0));
    put(32'h30, enc_i(4, 1, 3'b000, 1, 7'b1100111));
    put(32'h34, enc_b(8, 1, 1, 3'b000));
    put(32'h38, enc_s(20, 0, 0));
    put(32'h3c, enc_b(8, 1, 1, 3'b001));
    put(32'h40, enc_s(24, 2, 0));
    put(32'h44, enc_b(8, 4, 3, 3'b000));
    put(32'h48, enc_s(28, 4, 0));
    put(32'h4c, enc_b(8, 4, 3, 3'b001));
    put(32'h50, enc_s(0, 0, 0));
    put(32'h54, addi(1, 0, 5));
    put(32'h58, enc_s(8, 1, 0));
    put(32'h5c, enc_i(8, 0, 3'b010, 6, 7'b0000011));
    put(32'h60, enc_s(32, 6, 0));
    put(32'h64, enc_r(7'h01, 2, 1, 3'b000, 7));
    put(32'h68, enc_s(36, 7, 0));
    put(32'h6c, 32'h0000_0000);
    put(32'h70, addi(0, 0, 7));
    put(32'h74, enc_s(40, 0, 0));
    put(32'h78, enc_j(0, 0));

    cycle();
    cycle();
    check("rst_req_i", mem_req_I, 0);
    check("rst_req_d", mem_req_D, 0);
    check("rst_wen_d", mem_wen_D, 0);
    check("rst_retire", retire, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc", mem_addr_I, 32'h0);

`ifdef RV32_MUL_EN
    mul_res = 32'hFFFF_FFF1;
`else
    mul_res = 32'h0000_0000;
`endif
    pcs1 = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20, 32'h30,
             32'h28, 32'h2c, 32'h34, 32'h3c, 32'h40, 32'h44, 32'h48, 32'h4c, 32'h54, 32'h58,
             32'h5c, 32'h60, 32'h64, 32'h68, 32'h6c, 32'h70, 32'h74, 32'h78};
    foreach (pcs1[i]) exp_pc.push_back(pcs1[i]);
    push_st(0, 32'd2);
    push_st(4, 32'd1);
    push_st(12, 32'hFFFF_FFF8);
    push_st(16, 32'h34);
    push_st(24, 32'hFFFF_FFFD);
    push_st(28, 32'd1);
    push_st(8, 32'd5);
    push_st(32, 32'd5);
    push_st(36, mul_res);
    push_st(40, 32'd0);

    rst = 1'b0;
    spur = 1'b1;
    run_fetches("p1_pending_fetch", 3000);
    check("p1_sb_left", exp_st.size(), 0);
`ifdef RV32_MUL_EN
    check("p1_retires", ret_cnt, 26);
    check("mul_gap", ret_cyc[22] - ret_cyc[21], 34);
    check("mul_illegal", ill_snap, 0);
`else
    check("p1_retires", ret_cnt, 25);
    check("mul_gap", ret_cyc[22] - ret_cyc[21], 8);
    check("mul_illegal", ill_snap, 1);
`endif
    check("alu_gap0", ret_cyc[1] - ret_cyc[0], 2);
    check("alu_gap1", ret_cyc[2] - ret_cyc[1], 2);
    check("jal_gap", ret_cyc[9] - ret_cyc[8], 2);
    check("sw_gap", ret_cyc[5] - ret_cyc[4], 6);
    check("sw_wait_gap", ret_cyc[19] - ret_cyc[18], 6);
    check("lw_wait_gap", ret_cyc[20] - ret_cyc[19], 6);
    check("illegal_sticky", illegal, 1);

    // Abort a store that is still waiting on D-mem.
    rst = 1'b1;
    cycle();
    check("rst2_illegal", illegal, 0);
    check("rst2_req_i", mem_req_I, 0);
    for (int i = 0; i < 64; i++) imem[i] = swap(enc_j(0, 0));
    put(32'h00, addi(1, 0, 5));
    put(32'h04, enc_s(44, 1, 0));
    d_wait = 20;
    cycle();
    rst = 1'b0;
    exp_pc.push_back(32'h00);
    exp_pc.push_back(32'h04);
    for (int n = 0; n < 200 && !mem_req_D; n++) cycle();
    cycle();
    cycle();
    check("p2_in_mem", mem_req_D, 1);
    rst = 1'b1;
    cycle();
    check("abort_req_d", mem_req_D, 0);
    check("abort_wen_d", mem_wen_D, 0);
    check("abort_req_i", mem_req_I, 0);
    check("abort_pc", mem_addr_I, 32'h0);

    // After reset every register reads back as zero through stores.
    for (int i = 0; i < 64; i++) imem[i] = swap(enc_j(0, 0));
    put(32'h00, enc_s(48, 1, 0));
    put(32'h04, addi(0, 0, 7));
    put(32'h08, enc_s(52, 0, 0));
    put(32'h0c, enc_s(56, 6, 0));
    put(32'h10, enc_j(0, 0));
    i_wait = 2;
    d_wait = 1;
    cycle();
    rst = 1'b0;
    ret_cnt = 0;
    exp_pc.push_back(32'h00);
    exp_pc.push_back(32'h04);
    exp_pc.push_back(32'h08);
    exp_pc.push_back(32'h0c);
    exp_pc.push_back(32'h10);
    push_st(48, 32'd0);
    push_st(52, 32'd0);
    push_st(56, 32'd0);
    run_fetches("p3_pending_fetch", 500);
    check("p3_sb_left", exp_st.size(), 0);
    check("p3_retires", ret_cnt, 4);
    check("extra_fetch", n_xf, 0);
    check("extra_store", n_xs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
- Parametrised successor to the single-cycle RV32 datapath: a multi-cycle RV32I-subset core driven by an explicit FSM.
- Instruction and data memories connect through request/ready handshakes, so memory latency can vary.
- Sits at top level in place of the single-cycle core and talks to the same I-mem and D-mem models.
- Supported instructions: add, sub, and, or, slt, addi, slti, andi, ori, lw, sw, beq, bne, jal, jalr. Optionally mul.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, register count: 32 = RV32I, 16 = RV32E. Register fields index rs/rd[$clog2(NUM_REGS)-1:0]; higher bits are ignored.
- I_BYTE_SWAP, 1, when 1 the fetched word is byte-reversed ({b0,b1,b2,b3}) before decode. D-mem data is never swapped.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_req_I  out  1  instruction fetch request
- mem_addr_I  out  32  fetch address (=PC)
- mem_rdata_I  in  32  instruction word, valid when mem_ready_I=1
- mem_ready_I  in  1  fetch complete this cycle
- mem_req_D  out  1  data access request
- mem_wen_D  out  1  1=store, 0=load; valid while mem_req_D=1
- mem_addr_D  out  32  data byte address (word-aligned; bits[1:0] are passed through unchanged)
- mem_wdata_D  out  32  store data (rs2)
- mem_rdata_D  in  32  load data, valid when mem_ready_D=1
- mem_ready_D  in  1  data access complete this cycle
- retire  out  1  one-cycle pulse when an instruction commits
- illegal  out  1  sticky flag, set on an unsupported opcode/funct

Behaviour:
- Reset (clk edge with rst=1):
  - PC=RESET_PC, state=FETCH.
  - mem_req_I=0, mem_req_D=0, mem_wen_D=0, retire=0, illegal=0.
  - All registers cleared to 0.
  - rst overrides any in-flight handshake; an abandoned request is simply dropped, and memory must tolerate this.
- FETCH:
  - mem_req_I=1, mem_addr_I=PC, held stable until mem_ready_I.
  - On ready: latch (swapped) word into IR, go EXEC.
- EXEC (single cycle):
  - Decode IR, read rs1/rs2, compute ALU result and next PC.
  - R/I ALU ops: write rd, PC+=4, retire=1, go FETCH.
  - beq/bne: PC = taken ? PC+immB : PC+4; retire=1, go FETCH.
  - jal: rd=PC+4, PC=PC+immJ.
  - jalr: rd=PC+4, PC=(rs1+immI)&~1. Uses pre-write rs1 value, so rd==rs1 is safe.
  - lw/sw: latch addr=rs1+imm and wdata=rs2, go MEM.
  - Illegal instruction: set illegal, PC+=4, no write, retire=0.
- MEM:
  - mem_req_D=1, mem_wen_D=store; address and data held stable until mem_ready_D.
  - On ready: lw writes rd=mem_rdata_D. Then PC+=4, retire=1, go FETCH.
- Register x0:
  - Reads always return 0; writes to rd=0 are discarded.
  - With NUM_REGS=16, an index ≥16 aliases modulo 16 (no trap).
- Arithmetic:
  - 32-bit wrap-around; no overflow detection.
  - slt/slti are signed, result 0 or 1.
  - Immediates are sign-extended from bit 31.
- Latency:
  - ALU/branch/jump: (fetch wait + 1) + 1 cycles.
  - Load/store: additionally (data wait + 1).
  - With zero-wait memories: ALU=2 cycles, lw/sw=3 cycles.
- mem_ready_I/mem_ready_D asserted while the matching req=0 are ignored.

Optional Feature:
- Macro RV32_MUL_EN.
- Defined: decodes mul (funct7=0000001, funct3=000). A radix-2 shift-add multiplier runs in state MUL for 32 cycles, writes the low 32 bits to rd, then retires. rst aborts it.
- Undefined: mul is treated as illegal.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR)
  - funct3/funct7 constants
  - ALU op enum (ADD, SUB, AND, OR, SLT, MUL)
  - FSM state enum (FETCH, EXEC, MEM, MUL)
- One sub-module: rv32_regfile. Parameterised NUM_REGS, two combinational read ports, one synchronous write port, x0 hardwired to 0.
- ALU and immediate generation stay inline.

Test Plan:
- Zero-wait memories: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 → x3=2, retire pulses every 2 cycles, PC=12.
- slt x4,x2,x1 (-3<5) → x4=1; sub x5,x2,x1 → x5=0xFFFF_FFF8.
- mem_ready_D delayed 3 cycles on sw x1,8(x0) then lw x6,8(x0) → mem_addr_D=8 and mem_wdata_D=5 held stable throughout; x6=5; mem_ready_D pulsed while req=0 is ignored.
- beq taken/not-taken and bne; jal x1,+16 from PC=0x20 → x1=0x24, PC=0x30; jalr x1,4(x1) → PC=0x28.
- rst asserted mid-MEM with mem_req_D high → next cycle req=0, PC=RESET_PC, registers=0; addi x0,x0,7 → x0 reads 0.
- RV32_MUL_EN: mul x7,x1,x2 (5·-3) → x7=0xFFFF_FFF1 after 32 MUL cycles. Without the macro → illegal=1, x7 unchanged.
